// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared constants, state encoding and helpers for the VGA write arbiter
package vga_arb_pkg;

  localparam int SCR_W = 240;
  localparam int SCR_H = 320;
  localparam int X_W   = 8;
  localparam int Y_W   = 9;
  localparam int C_W   = 3;

  localparam logic [0:0] ARB = 1'b0;
  localparam logic [0:0] OWN = 1'b1;

  localparam logic [C_W-1:0] WHITE = 3'b111;
  localparam logic [C_W-1:0] BLACK = 3'b000;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pixel_t;

  // Round-robin successor over indices 0..2; 2 wraps back to 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // True when the pixel lands on the visible screen area.
  function automatic logic in_screen(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
    return (px < X_W'(SCR_W)) && (py < Y_W'(SCR_H));
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational 3-way round-robin selector starting at ptr
module rr_pick3
  import vga_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  logic [2:0] rot;
  logic [1:0] off;
  logic [2:0] sum;

  // Rotate so rot[0] is the pointer's requester, then take the first set bit and map back.
  always_comb begin
    any = |valid;
    case (ptr)
      2'd1:    rot = {valid[0], valid[2], valid[1]};
      2'd2:    rot = {valid[1], valid[0], valid[2]};
      default: rot = valid;
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - burst round-robin arbiter for the VGA pixel-write port (option: VGA_ARB_CLIP_EN)
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int BURST_TIMEOUT = 16
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*X_W-1:0]   req_x,
  input  logic [NREQ*Y_W-1:0]   req_y,
  input  logic [NREQ*C_W-1:0]   req_color,
  output logic [NREQ-1:0]       req_ready,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [C_W-1:0]        color,
  output logic                  write_en,
`ifdef VGA_ARB_CLIP_EN
  output logic                  clip_pulse,
`endif
  output logic                  busy,
  output logic [1:0]            owner
);

  localparam int TW = $clog2(BURST_TIMEOUT + 1);

  logic [0:0]    state;
  logic [1:0]    ptr;
  logic [1:0]    owner_q;
  logic [TW-1:0] tcnt;

  logic [1:0]    win;
  logic          any;
  logic          own_valid;
  logic          own_last;
  pixel_t        own_pix;
  logic          accept;
  logic          timed_out;

  rr_pick3 u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .win   (win),
    .any   (any)
  );

  // Steer the current owner's stream slice onto internal wires.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_pix   = '0;
    case (owner_q)
      2'd0: begin
        own_valid = req_valid[0];
        own_last  = req_last[0];
        own_pix   = {req_x[7:0], req_y[8:0], req_color[2:0]};
      end
      2'd1: begin
        own_valid = req_valid[1];
        own_last  = req_last[1];
        own_pix   = {req_x[15:8], req_y[17:9], req_color[5:3]};
      end
      2'd2: begin
        own_valid = req_valid[2];
        own_last  = req_last[2];
        own_pix   = {req_x[23:16], req_y[26:18], req_color[8:6]};
      end
      default: ;
    endcase
  end

  // Ready is a pure decode of registered state so the arbitration cycle never grants.
  always_comb begin
    req_ready = '0;
    if (state == OWN) begin
      case (owner_q)
        2'd0:    req_ready = 3'b001;
        2'd1:    req_ready = 3'b010;
        2'd2:    req_ready = 3'b100;
        default: req_ready = 3'b000;
      endcase
    end
  end

  assign accept    = (state == OWN) && own_valid;
  assign timed_out = (state == OWN) && !own_valid && (tcnt == TW'(BURST_TIMEOUT - 1));
  assign busy      = (state == OWN);
  assign owner     = owner_q;

  // Ownership sequencing: grant in ARB, release on accepted last or idle timeout.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      ptr     <= 2'd0;
      owner_q <= 2'd0;
      tcnt    <= '0;
    end else begin
      case (state)
        ARB: begin
          tcnt <= '0;
          if (any) begin
            owner_q <= win;
            state   <= OWN;
          end
        end
        default: begin
          if (accept) begin
            tcnt <= '0;
            if (own_last) begin
              state <= ARB;
              ptr   <= next_idx(owner_q);
            end
          end else if (timed_out) begin
            tcnt  <= '0;
            state <= ARB;
            ptr   <= next_idx(owner_q);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

  // Adapter-side registers: one write strobe per accepted pixel, data held otherwise.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      color    <= BLACK;
      write_en <= 1'b0;
`ifdef VGA_ARB_CLIP_EN
      clip_pulse <= 1'b0;
`endif
    end else begin
`ifdef VGA_ARB_CLIP_EN
      write_en   <= accept && in_screen(own_pix.x, own_pix.y);
      clip_pulse <= accept && !in_screen(own_pix.x, own_pix.y);
`else
      write_en <= accept;
`endif
      if (accept) begin
        x     <= own_pix.x;
        y     <= own_pix.y;
        color <= own_pix.c;
      end
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - directed and randomized self-checking bench for vga_write_arbiter
module tb_vga_write_arbiter;

  logic        clk50M = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [23:0] req_x;
  logic [26:0] req_y;
  logic [8:0]  req_color;
  logic [2:0]  req_ready;
  logic [7:0]  x;
  logic [8:0]  y;
  logic [2:0]  color;
  logic        write_en;
  logic        busy;
  logic [1:0]  owner;
`ifdef VGA_ARB_CLIP_EN
  logic        clip_pulse;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] px;
    logic [8:0] py;
    logic [2:0] pc;
    logic       pl;
  } pix_t;

  pix_t src [3][$];
  pix_t expq [$];
  int   exp_own [$];
  int   gap [3];
  bit   gap_en;
  int   model_ptr;

  vga_write_arbiter dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_color (req_color),
    .req_ready (req_ready),
    .x         (x),
    .y         (y),
    .color     (color),
    .write_en  (write_en),
`ifdef VGA_ARB_CLIP_EN
    .clip_pulse(clip_pulse),
`endif
    .busy      (busy),
    .owner     (owner)
  );

  always #10 clk50M = ~clk50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [7:0] px, input logic [8:0] py,
                         input logic [2:0] pc, input logic v, input logic l);
    req_x[i*8 +: 8]     = px;
    req_y[i*9 +: 9]     = py;
    req_color[i*3 +: 3] = pc;
    req_valid[i]        = v;
    req_last[i]         = l;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (src[i].size() > 0)
        set_pix(i, src[i][0].px, src[i][0].py, src[i][0].pc, (gap[i] == 0), src[i][0].pl);
      else
        set_pix(i, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic add_burst(input int i, input int len, input bit rnd, input int base);
    pix_t p;
    for (int k = 0; k < len; k++) begin
      p.px = rnd ? 8'($urandom_range(0, 239)) : 8'(base + k);
      p.py = rnd ? 9'($urandom_range(0, 319)) : 9'(i + 1);
      p.pc = rnd ? 3'($urandom_range(0, 7))   : 3'(i + 1);
      p.pl = (k == len - 1);
      src[i].push_back(p);
    end
  endtask

  // Burst-level model: every requester with work is valid at each arbitration,
  // so grants rotate from the pointer and whole bursts are written in that order.
  task automatic build_expect(input int start);
    pix_t cp [3][$];
    pix_t p;
    int   pt;
    int   sel;
    for (int i = 0; i < 3; i++) cp[i] = src[i];
    pt = start;
    forever begin
      sel = -1;
      for (int j = 0; j < 3; j++) begin
        if (sel < 0 && cp[(pt + j) % 3].size() > 0) sel = (pt + j) % 3;
      end
      if (sel < 0) break;
      exp_own.push_back(sel);
      do begin
        p = cp[sel].pop_front();
        expq.push_back(p);
      end while (!p.pl);
      pt = (sel + 1) % 3;
    end
  endtask

  task automatic run_engine(input int budget);
    pix_t       pend;
    pix_t       p;
    pix_t       e;
    bit         pend_we;
    bit         prev_busy;
    bit         prev_last;
    bit         done;
    int         last_own;
    logic [2:0] acc;
    build_expect(model_ptr);
    drive();
    pend      = '0;
    pend_we   = 0;
    prev_busy = 0;
    prev_last = 0;
    done      = 0;
    last_own  = model_ptr;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk50M);
      check("eng_write_en", 32'(write_en), 32'(pend_we));
      if (pend_we) check("eng_pixel", 32'({x, y, color}), 32'({pend.px, pend.py, pend.pc}));
      pend_we = 0;
      if (busy && !prev_busy) begin
        if (exp_own.size() > 0) check("eng_owner", 32'(owner), 32'(exp_own.pop_front()));
        else check("eng_extra_grant", 32'(owner), 32'hffff);
        last_own = owner;
      end
      prev_busy = busy;
      check("eng_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      acc = req_valid & req_ready;
      if (prev_last) check("eng_bubble", 32'(acc), 32'd0);
      prev_last = 0;
      if (src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0) begin
        done = 1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (acc[i]) begin
            p = src[i].pop_front();
            if (expq.size() > 0) begin
              e = expq.pop_front();
              check("eng_order", 32'(p), 32'(e));
            end else begin
              check("eng_unexpected_accept", 32'(p), 32'hffff_ffff);
            end
            pend      = p;
            pend_we   = 1;
            prev_last = p.pl;
            gap[i]    = (!p.pl && gap_en && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
          end else if (gap[i] > 0) begin
            gap[i]--;
          end
        end
        @(posedge clk50M);
        #1;
        drive();
      end
    end
    check("eng_done", 32'(done), 32'd1);
    check("eng_leftover", 32'(expq.size()), 32'd0);
    expq.delete();
    exp_own.delete();
    model_ptr = (last_own + 1) % 3;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_x     = '0;
    req_y     = '0;
    req_color = '0;
    gap_en    = 0;
    model_ptr = 0;
    for (int i = 0; i < 3; i++) gap[i] = 0;
    tick();
    tick();
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_xyc", 32'({x, y, color}), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    tick();

    // single 4-pixel burst from req0
    set_pix(0, 8'd0, 9'd5, 3'b111, 1'b1, 1'b0);
    tick();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_owner", 32'(owner), 32'd0);
    check("t2_ready", 32'(req_ready), 32'b001);
    check("t2_bubble_we", 32'(write_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      set_pix(0, 8'(k), 9'd5, 3'b111, 1'b1, (k == 3));
      tick();
      check("t2_we", 32'(write_en), 32'd1);
      check("t2_x", 32'(x), 32'(k));
      check("t2_y", 32'(y), 32'd5);
      check("t2_color", 32'(color), 32'b111);
    end
    set_pix(0, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_ready_end", 32'(req_ready), 32'd0);
    tick();
    check("t2_we_end", 32'(write_en), 32'd0);

    // pointer is now 1: req1 beats req0, then reset lands mid-burst
    set_pix(0, 8'd9, 9'd9, 3'd1, 1'b1, 1'b0);
    set_pix(1, 8'd50, 9'd60, 3'd2, 1'b1, 1'b0);
    tick();
    check("t1_owner", 32'(owner), 32'd1);
    tick();
    check("t1_we", 32'(write_en), 32'd1);
    check("t1_x", 32'(x), 32'd50);
    set_pix(1, 8'd51, 9'd61, 3'd2, 1'b1, 1'b0);
    #4;
    rst = 1'b1;
    #1;
    check("t1_async_we", 32'(write_en), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_ready", 32'(req_ready), 32'd0);
    check("t1_async_xyc", 32'({x, y, color}), 32'd0);
    tick();
    check("t1_edge_we", 32'(write_en), 32'd0);
    check("t1_edge_busy", 32'(busy), 32'd0);
    check("t1_edge_ready", 32'(req_ready), 32'd0);
    check("t1_edge_xyc", 32'({x, y, color}), 32'd0);
    req_valid = '0;
    req_last  = '0;
    rst       = 1'b0;
    tick();
    model_ptr = 0;

    // fairness with everyone valid: owners 0,1,2,0
    add_burst(0, 2, 0, 0);
    add_burst(1, 2, 0, 100);
    add_burst(2, 2, 0, 200);
    add_burst(0, 2, 0, 10);
    run_engine(200);

    // move pointer to 2, then only req0 and req2 compete: 2 wins, then 0
    add_burst(1, 1, 0, 30);
    run_engine(50);
    add_burst(0, 2, 0, 40);
    add_burst(2, 2, 0, 50);
    run_engine(50);

    // timeout: req2 sends one pixel and goes idle
    set_pix(2, 8'd7, 9'd7, 3'd3, 1'b1, 1'b0);
    tick();
    check("t4_owner", 32'(owner), 32'd2);
    tick();
    check("t4_we", 32'(write_en), 32'd1);
    set_pix(2, 8'd0, 9'd0, 3'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) tick();
    check("t4_still_busy", 32'(busy), 32'd1);
    tick();
    check("t4_released", 32'(busy), 32'd0);
    check("t4_no_write", 32'(write_en), 32'd0);
    set_pix(0, 8'd60, 9'd70, 3'd4, 1'b1, 1'b1);
    set_pix(2, 8'd61, 9'd71, 3'd5, 1'b1, 1'b0);
    tick();
    check("t4_next_owner", 32'(owner), 32'd0);
    tick();
    check("t4_next_x", 32'(x), 32'd60);
    check("t4_next_busy", 32'(busy), 32'd0);
    req_valid = '0;
    req_last  = '0;
    tick();

    // off-screen pixel from req1
    set_pix(1, 8'd240, 9'd10, 3'd6, 1'b1, 1'b1);
    tick();
    check("t5_owner", 32'(owner), 32'd1);
    tick();
    req_valid = '0;
    req_last  = '0;
`ifdef VGA_ARB_CLIP_EN
    check("t5_clip_we", 32'(write_en), 32'd0);
    check("t5_clip_pulse", 32'(clip_pulse), 32'd1);
`else
    check("t5_we", 32'(write_en), 32'd1);
    check("t5_x", 32'(x), 32'd240);
`endif
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    check("t5_we_after", 32'(write_en), 32'd0);
`ifdef VGA_ARB_CLIP_EN
    check("t5_pulse_after", 32'(clip_pulse), 32'd0);
`endif
    model_ptr = 2;

    // randomized bursts with mid-burst gaps
    gap_en = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        int nb;
        nb = int'($urandom_range(1, 4));
        for (int b = 0; b < nb; b++) add_burst(i, int'($urandom_range(1, 5)), 1, 0);
      end
      run_engine(2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
